// File: rtl/ff_monitor.sv
// ff_monitor: run-time checker for a single-bit D flop.
// Predicts q one cycle behind d (0 while the flop is held in reset) and tallies mismatches over a programmed run.
module ff_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             d,
  input  logic             dut_rst,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       state_r;
  logic [CNT_W-1:0] remaining_r;
  logic             exp_q_r;
  logic             mism_s;
  logic             next_exp_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return CNT_MAX;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Compare decision for this edge and the prediction for the next one
  always_comb begin
    mism_s     = 1'b0;
    next_exp_s = 1'b0;
    if (dut_rst) begin
      mism_s     = (q != 1'b0);
      next_exp_s = 1'b0;
    end else begin
      mism_s     = (q != exp_q_r);
      next_exp_s = d;
    end
  end

  // Run FSM, result counters and prediction register
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_r       <= IDLE;
      remaining_r   <= CNT_ZERO;
      exp_q_r       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      chk_cnt       <= CNT_ZERO;
      err_cnt       <= CNT_ZERO;
      first_err_idx <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            chk_cnt       <= CNT_ZERO;
            err_cnt       <= CNT_ZERO;
            err           <= 1'b0;
            first_err_idx <= CNT_ZERO;
            remaining_r   <= len;
            exp_q_r       <= next_exp_s;
            if (len != CNT_ZERO) begin
              state_r <= CHECK;
              busy    <= 1'b1;
            end else begin
              state_r <= DONE;
              done    <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CHECK: begin
          chk_cnt     <= sat_inc(chk_cnt);
          exp_q_r     <= next_exp_s;
          remaining_r <= remaining_r - CNT_ONE;
          if (mism_s) begin
            err_cnt <= sat_inc(err_cnt);
            if (!err) begin
              first_err_idx <= chk_cnt;
              err           <= 1'b1;
            end else begin
              first_err_idx <= first_err_idx;
            end
          end else begin
            err_cnt <= err_cnt;
          end
          // The final compare of the run hands over to the one-cycle DONE pulse
          if (remaining_r == CNT_ONE) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= CHECK;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff_monitor.sv
// Self-checking bench for ff_monitor: a correct async-reset flop with fault injection on q,
// a queue-based reference model checked every cycle, plus directed literal checks.
module tb_ff_monitor;

  logic       clk = 1'b0;
  logic       rest, start, start4, d, dut_rst, inj;
  logic [7:0] len;
  logic       ff_q;
  logic       q;

  logic       busy, done, err;
  logic [7:0] chk_cnt, err_cnt, first_err_idx;
  logic       busy4, done4, err4;
  logic [3:0] chk4, errc4, first4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Reference flop being monitored; inj flips its observed output
  always @(posedge clk or posedge dut_rst) begin
    if (dut_rst) ff_q <= 1'b0;
    else         ff_q <= d;
  end
  assign q = ff_q ^ inj;

  ff_monitor #(.CNT_W(8)) dut (
    .clk(clk), .rest(rest), .start(start), .len(len), .d(d), .dut_rst(dut_rst), .q(q),
    .busy(busy), .done(done), .err(err), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx)
  );

  ff_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rest(rest), .start(start4), .len(len[3:0]), .d(d), .dut_rst(dut_rst), .q(q),
    .busy(busy4), .done(done4), .err(err4), .chk_cnt(chk4), .err_cnt(errc4),
    .first_err_idx(first4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] ln, input logic dd,
                       input logic dr, input logic fi);
    @(negedge clk);
    start = st; len = ln; d = dd; dut_rst = dr; inj = fi;
  endtask

  // Reference model: a run is the list of per-compare mismatch flags; every output follows from it
  initial begin
    logic       s_start, s_d, s_rst, s_q, s_rest;
    logic [7:0] s_len;
    bit         m_active, m_done, m_prev;
    int         m_len, errs, first, nchk;
    bit         m_mism[$];
    m_active = 1'b0; m_done = 1'b0; m_prev = 1'b0; m_len = 0;
    forever begin
      @(posedge clk);
      s_start = start; s_len = len; s_d = d; s_rst = dut_rst; s_q = q; s_rest = rest;
      #1;
      m_done = 1'b0;
      if (s_rest) begin
        m_active = 1'b0; m_prev = 1'b0; m_len = 0;
        m_mism.delete();
      end else if (m_active) begin
        m_mism.push_back(s_q != (s_rst ? 1'b0 : m_prev));
        m_prev = s_rst ? 1'b0 : s_d;
        if (m_mism.size() == m_len) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end else if (s_start) begin
        m_mism.delete();
        m_len  = int'(s_len);
        m_prev = s_rst ? 1'b0 : s_d;
        if (m_len == 0) m_done = 1'b1;
        else            m_active = 1'b1;
      end
      errs = 0; first = -1;
      foreach (m_mism[i]) begin
        if (m_mism[i]) begin
          errs++;
          if (first < 0) first = i;
        end
      end
      nchk = m_mism.size();
      check("model_busy",  32'(busy), 32'(m_active));
      check("model_done",  32'(done), 32'(m_done));
      check("model_err",   32'(err), (errs > 0) ? 32'd1 : 32'd0);
      check("model_chk",   32'(chk_cnt), (nchk > 255) ? 32'd255 : 32'(nchk));
      check("model_errc",  32'(err_cnt), (errs > 255) ? 32'd255 : 32'(errs));
      check("model_first", 32'(first_err_idx), (first < 0) ? 32'd0 : 32'(first));
    end
  end

  initial begin
    logic [5:0] pat;
    rest = 1'b1; start = 1'b0; start4 = 1'b0; len = 8'd0; d = 1'b0; dut_rst = 1'b0; inj = 1'b0;
    repeat (3) @(negedge clk);
    rest = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_chk",  32'(chk_cnt), 32'd0);
    check("rst_errc", 32'(err_cnt), 32'd0);

    // Clean run, d = 0,1,0,1,1,0
    pat = 6'b011010;
    drive(1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) drive(1'b0, 8'd0, pat[c], 1'b0, 1'b0);
    check("clean_done_early", 32'(done), 32'd0);
    @(posedge clk); #2;
    check("clean_done", 32'(done), 32'd1);
    check("clean_chk",  32'(chk_cnt), 32'd6);
    check("clean_errc", 32'(err_cnt), 32'd0);
    check("clean_err",  32'(err), 32'd0);

    // Injected faults on compares 2 and 4
    drive(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++)
      drive(1'b0, 8'd0, 1'($urandom_range(0, 1)), 1'b0, (c == 2 || c == 4) ? 1'b1 : 1'b0);
    @(posedge clk); #2;
    check("fault_errc",  32'(err_cnt), 32'd2);
    check("fault_err",   32'(err), 32'd1);
    check("fault_first", 32'(first_err_idx), 32'd2);
    check("fault_chk",   32'(chk_cnt), 32'd5);

    // Zero-length run clears old results
    drive(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("zero_done", 32'(done), 32'd1);
    check("zero_chk",  32'(chk_cnt), 32'd0);
    check("zero_errc", 32'(err_cnt), 32'd0);
    check("zero_err",  32'(err), 32'd0);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("zero_done_clr", 32'(done), 32'd0);

    // Flop held in reset for the first two compares, first clean then with q forced high
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b1, 8'd4, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 8'd0, 1'b1, 1'b1, (pass == 1) ? 1'b1 : 1'b0);
      drive(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #2;
      check("rstwin_chk",  32'(chk_cnt), 32'd4);
      check("rstwin_errc", 32'(err_cnt), (pass == 1) ? 32'd1 : 32'd0);
      check("rstwin_err",  32'(err), (pass == 1) ? 32'd1 : 32'd0);
      check("rstwin_first", 32'(first_err_idx), 32'd0);
    end

    // start during a run is ignored
    drive(1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("busy_start_done", 32'(done), 32'd1);
    check("busy_start_chk",  32'(chk_cnt), 32'd4);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("busy_start_idle", 32'(busy), 32'd0);

    // Saturation on the 4-bit instance: 15 compares, all wrong
    drive(1'b0, 8'd15, 1'b0, 1'b0, 1'b1);
    start4 = 1'b1;
    for (int c = 0; c < 15; c++) begin
      drive(1'b0, 8'd15, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      start4 = 1'b0;
    end
    check("sat_done_early", 32'(done4), 32'd0);
    @(posedge clk); #2;
    check("sat_done",  32'(done4), 32'd1);
    check("sat_chk",   32'(chk4), 32'd15);
    check("sat_errc",  32'(errc4), 32'd15);
    check("sat_err",   32'(err4), 32'd1);
    check("sat_first", 32'(first4), 32'd0);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("sat_done_clr", 32'(done4), 32'd0);
    check("sat_busy_clr", 32'(busy4), 32'd0);

    // Asynchronous reset in the middle of a len = 8 run
    drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("mid_chk_before", 32'(chk_cnt), 32'd3);
    check("mid_err_before", 32'(err), 32'd1);
    #1 rest = 1'b1;
    #1;
    check("mid_busy",  32'(busy), 32'd0);
    check("mid_done",  32'(done), 32'd0);
    check("mid_err",   32'(err), 32'd0);
    check("mid_chk",   32'(chk_cnt), 32'd0);
    check("mid_errc",  32'(err_cnt), 32'd0);
    check("mid_first", 32'(first_err_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rest = 1'b0;
    drive(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) drive(1'b0, 8'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    @(posedge clk); #2;
    check("after_rst_done", 32'(done), 32'd1);
    check("after_rst_chk",  32'(chk_cnt), 32'd3);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 60)) : 8'($urandom_range(0, 12)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    end
    repeat (80) drive(1'b0, 8'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    @(posedge clk); #3;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
